result_capture_ctrl: RTL and testbench

Write-side companion to the memory control top. It accepts the 56-bit result stream, one word per valid cycle, and stores it in an internal 512-entry result memory. On command it plays the stored words back in order with address tags, so a bench or downstream block can compare them against a golden file. The block is a three-state controller: capture, full, drain.

---
 rtl/result_capture_ctrl.sv | 178 +++++++++++++++++
 tb/tb_result_capture_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_capture_ctrl.sv
// Result capture controller: stores the result stream into a 512-entry memory and
// plays it back in order with address tags on a drain command.
module result_capture_ctrl #(
  parameter int DATA_W = 56,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              drain_start,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ADDR_W:0]   wr_count,
  output logic              full,
  output logic              overflow,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_FULL    = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_ZERO = (ADDR_W+1)'(0);

  logic [DATA_W-1:0] mem_r [DEPTH];

  state_t            state_r, state_s;
  logic [ADDR_W:0]   wr_count_r, wr_count_s;
  logic [ADDR_W:0]   rd_ptr_r, rd_ptr_s;
  logic              rd_vld_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              arm_r, arm_s;
  logic              overflow_r, overflow_s;
  logic              done_r, done_s;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic [ADDR_W-1:0] out_addr_r;
  logic              wr_en_s, rd_en_s;

  // Next-state, memory strobes and counter updates for the capture/full/drain controller.
  always_comb begin
    state_s    = state_r;
    wr_count_s = wr_count_r;
    rd_ptr_s   = rd_ptr_r;
    arm_s      = 1'b0;
    overflow_s = overflow_r;
    done_s     = 1'b0;
    wr_en_s    = 1'b0;
    rd_en_s    = 1'b0;
    case (state_r)
      ST_CAPTURE: begin
        if (in_valid) begin
          wr_en_s    = rstn & ~clear;
          wr_count_s = wr_count_r + CNT_ONE;
          if ((wr_count_r + CNT_ONE) == DEPTH_C) begin
            state_s = ST_FULL;
          end else begin
            state_s = ST_CAPTURE;
          end
        end else begin
          wr_count_s = wr_count_r;
        end
        if (drain_start) begin
          state_s  = ST_DRAIN;
          rd_ptr_s = CNT_ZERO;
          arm_s    = 1'b1;
        end else begin
          rd_ptr_s = rd_ptr_r;
        end
      end
      ST_FULL: begin
        if (in_valid) begin
          overflow_s = 1'b1;
        end else begin
          overflow_s = overflow_r;
        end
        if (drain_start) begin
          state_s  = ST_DRAIN;
          rd_ptr_s = CNT_ZERO;
          arm_s    = 1'b1;
        end else begin
          state_s = ST_FULL;
        end
      end
      ST_DRAIN: begin
        if (in_valid) begin
          overflow_s = 1'b1;
        end else begin
          overflow_s = overflow_r;
        end
        // Finish only once the last read has left the pipeline; arm_r delays the empty-drain case by one cycle.
        if (rd_ptr_r != wr_count_r) begin
          rd_en_s  = 1'b1;
          rd_ptr_s = rd_ptr_r + CNT_ONE;
        end else if (!rd_vld_r && !arm_r) begin
          done_s     = 1'b1;
          state_s    = ST_CAPTURE;
          wr_count_s = CNT_ZERO;
        end else begin
          rd_ptr_s = rd_ptr_r;
        end
      end
      default: begin
        state_s = ST_CAPTURE;
      end
    endcase
  end

  // Result memory: one write port, one synchronous read port.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_count_r[ADDR_W-1:0]] <= in_data;
    end
    if (rd_en_s) begin
      rd_data_r <= mem_r[rd_ptr_r[ADDR_W-1:0]];
    end
  end

  // Control state, read pipeline and registered outputs; clear keeps out_data.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= ST_CAPTURE;
      wr_count_r  <= CNT_ZERO;
      rd_ptr_r    <= CNT_ZERO;
      rd_vld_r    <= 1'b0;
      rd_addr_r   <= '0;
      arm_r       <= 1'b0;
      overflow_r  <= 1'b0;
      done_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_addr_r  <= '0;
      out_data_r  <= '0;
    end else if (clear) begin
      state_r     <= ST_CAPTURE;
      wr_count_r  <= CNT_ZERO;
      rd_ptr_r    <= CNT_ZERO;
      rd_vld_r    <= 1'b0;
      rd_addr_r   <= '0;
      arm_r       <= 1'b0;
      overflow_r  <= 1'b0;
      done_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_addr_r  <= '0;
    end else begin
      state_r     <= state_s;
      wr_count_r  <= wr_count_s;
      rd_ptr_r    <= rd_ptr_s;
      rd_vld_r    <= rd_en_s;
      rd_addr_r   <= rd_ptr_r[ADDR_W-1:0];
      arm_r       <= arm_s;
      overflow_r  <= overflow_s;
      done_r      <= done_s;
      out_valid_r <= rd_vld_r;
      if (rd_vld_r) begin
        out_addr_r <= rd_addr_r;
        out_data_r <= rd_data_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_addr  = out_addr_r;
  assign wr_count  = wr_count_r;
  assign full      = (wr_count_r == DEPTH_C);
  assign overflow  = overflow_r;
  assign done      = done_r;

endmodule

// File: tb/tb_result_capture_ctrl.sv
// Scoreboard bench for result_capture_ctrl: stimulus pushes expected words (with
// their expected cycle) and done pulses; a negedge monitor pops and compares.
module tb_result_capture_ctrl;

  logic        clk = 1'b0;
  logic        rstn, clear, in_valid, drain_start;
  logic [55:0] in_data;
  logic        out_valid, full, overflow, done;
  logic [55:0] out_data;
  logic [8:0]  out_addr;
  logic [9:0]  wr_count;

  typedef struct packed {
    int unsigned cyc;
    logic [8:0]  addr;
    logic [55:0] data;
  } exp_t;

  exp_t        exp_q [$];
  int unsigned done_q [$];
  exp_t        mon_e;
  int unsigned mon_c;
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  logic [55:0] m_mem [512];
  int          m_cnt = 0;
  logic        m_ovf = 1'b0;

  result_capture_ctrl dut (
    .clk(clk), .rstn(rstn), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .drain_start(drain_start), .out_valid(out_valid), .out_data(out_data),
    .out_addr(out_addr), .wr_count(wr_count), .full(full), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every out_valid word and every done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_word: got addr %0d data %0h at cycle %0d, expected no word", out_addr, out_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_addr !== mon_e.addr || out_data !== mon_e.data || cyc != mon_e.cyc) begin
          n_bad++;
          $display("FAIL drain_word: got addr %0d data %0h cycle %0d, expected addr %0d data %0h cycle %0d",
                   out_addr, out_data, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
        end
      end
    end
    if (done === 1'b1) begin
      n_vec++;
      if (done_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        mon_c = done_q.pop_front();
        if (cyc != mon_c || out_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL done_pulse: got cycle %0d out_valid %b, expected cycle %0d out_valid 0", cyc, out_valid, mon_c);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [55:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    if (m_cnt < 512) begin
      m_mem[m_cnt] = d;
      m_cnt++;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  // Pulse drain_start (optionally with a same-cycle write); expect up to 'limit' words.
  task automatic start_drain(input logic with_wr, input logic [55:0] d, input int limit);
    int unsigned t;
    t = cyc + 1;
    drain_start = 1'b1;
    if (with_wr) begin
      in_valid = 1'b1;
      in_data  = d;
      m_mem[m_cnt] = d;
      m_cnt++;
    end
    for (int k = 0; k < m_cnt && k < limit; k++) begin
      exp_q.push_back('{cyc: t + 2 + k, addr: 9'(k), data: m_mem[k]});
    end
    if (limit >= m_cnt) begin
      done_q.push_back(t + 2 + m_cnt);
    end
    step();
    drain_start = 1'b0;
    in_valid    = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_q.size() == 0) break;
    end
    if (done_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: got no done after %0d cycles, expected done", budget);
      done_q.delete();
      exp_q.delete();
    end
    m_cnt = 0;
  endtask

  initial begin
    rstn = 1'b0; clear = 1'b0; drain_start = 1'b0;
    in_valid = 1'b1; in_data = 56'h0000_0000_00ABCD;
    repeat (2) step();
    check("rst_wr_count", 64'(wr_count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    rstn = 1'b1; in_valid = 1'b0;

    // Capture four words and drain them.
    for (int i = 1; i <= 4; i++) write_word(56'(i));
    check("cap4_wr_count", 64'(wr_count), 64'd4);
    start_drain(1'b0, 56'd0, 1024);
    wait_done(20);
    check("drain4_wr_count", 64'(wr_count), 64'd0);

    // First write lands in the done cycle; the fourth write shares drain_start.
    write_word(56'h00_0000_0000_00A1);
    write_word(56'h00_0000_0000_00A2);
    write_word(56'h00_0000_0000_00A3);
    start_drain(1'b1, 56'h00_0000_0000_00A4, 1024);
    wait_done(20);

    // Empty drain: done two edges after drain_start, no words.
    start_drain(1'b0, 56'd0, 1024);
    wait_done(10);
    check("empty_wr_count", 64'(wr_count), 64'd0);

    // in_valid during a drain is dropped and sets overflow.
    for (int i = 0; i < 5; i++) write_word(56'h12_3456_0000_0000 + 56'(i));
    start_drain(1'b0, 56'd0, 1024);
    in_valid = 1'b1; in_data = 56'hDE_ADBE_EFDE_ADBE;
    step(); step();
    in_valid = 1'b0;
    m_ovf = 1'b1;
    wait_done(20);
    check("drain_ovf", 64'(overflow), 64'(m_ovf));
    check("drain_ovf_wr_count", 64'(wr_count), 64'd0);

    // Clear on the third output word of a ten-word drain.
    for (int i = 0; i < 10; i++) write_word(56'h0F_0000_0000_0000 + 56'(i * 3));
    start_drain(1'b0, 56'd0, 3);
    repeat (4) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    m_cnt = 0; m_ovf = 1'b0;
    check("clr_out_valid", 64'(out_valid), 64'd0);
    check("clr_wr_count", 64'(wr_count), 64'd0);
    check("clr_overflow", 64'(overflow), 64'(m_ovf));
    check("clr_out_data_hold", 64'(out_data), 64'h0F_0000_0000_0006);
    repeat (20) step();
    check("clr_no_pending", 64'(exp_q.size() + done_q.size()), 64'd0);

    // rstn during capture discards the stored words.
    for (int i = 0; i < 3; i++) write_word(56'h55_0000_0000_0000 + 56'(i));
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    m_cnt = 0;
    check("rstcap_wr_count", 64'(wr_count), 64'd0);
    check("rstcap_out_data", 64'(out_data), 64'd0);
    start_drain(1'b0, 56'd0, 1024);
    wait_done(10);

    // Fill all 512 entries, then overflow.
    for (int i = 0; i < 512; i++) begin
      if (i == 511) begin
        check("fill511_full", 64'(full), 64'd0);
        check("fill511_wr_count", 64'(wr_count), 64'd511);
      end
      write_word(56'(i));
    end
    check("fill_full", 64'(full), 64'd1);
    check("fill_wr_count", 64'(wr_count), 64'd512);
    check("fill_overflow", 64'(overflow), 64'd0);
    write_word(56'h77_7777_7777_7777);
    check("ovf_overflow", 64'(overflow), 64'(m_ovf));
    check("ovf_wr_count", 64'(wr_count), 64'd512);
    start_drain(1'b0, 56'd0, 1024);
    wait_done(600);
    check("drain512_overflow", 64'(overflow), 64'd1);
    check("drain512_wr_count", 64'(wr_count), 64'd0);
    check("drain512_full", 64'(full), 64'd0);

    repeat (5) step();
    check("end_no_pending", 64'(exp_q.size() + done_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
